// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port RAM slave: classic cycles plus registered-feedback incrementing
// bursts (linear, wrap-4/8/16), byte lanes and error termination for out-of-range addresses.
module wb_burst_ram #(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned mem_size_bytes = 32'h0002_0000,
  parameter int unsigned mem_adr_width  = 17
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic [dw-1:0]   wb_dat_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int unsigned   Depth    = mem_size_bytes / 4;
  localparam int unsigned   Iw       = mem_adr_width - 2;
  localparam logic [aw-1:0] MemLimit = aw'(mem_size_bytes);
  localparam logic [2:0]    CtiIncr  = 3'b010;
  localparam logic          StIdle   = 1'b0;
  localparam logic          StBurst  = 1'b1;

  logic [dw-1:0] mem [Depth];

  logic          state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [dw-1:0] dat_q, dat_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic [1:0]    bte_q, bte_d;

  logic          req;
  logic          wr_en;
  logic [Iw-1:0] wr_idx;
  logic [Iw-1:0] rd_idx;
  logic [dw-1:0] rd_word;

  // Increment the word index inside the wrap field; bits above it are held.
  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a, input logic [1:0] bte);
    logic [aw-1:0] n;
    n = a;
    case (bte)
      2'b00:   n = a + aw'(4);
      2'b01:   n[3:2] = a[3:2] + 2'd1;
      2'b10:   n[4:2] = a[4:2] + 3'd1;
      default: n[5:2] = a[5:2] + 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic in_range(input logic [aw-1:0] a);
    return a < MemLimit;
  endfunction

  assign req      = wb_cyc_i & wb_stb_i;
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & req;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;

  assign wr_en  = wb_ack_o & wb_we_i;
  assign wr_idx = wb_adr_i[mem_adr_width-1:2];
  assign rd_idx = (state_q == StBurst) ? cnt_q[mem_adr_width-1:2] : wr_idx;

  // Write-first: a beat writing the word being prefetched forwards the new bytes.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      for (int i = 0; i < dw / 8; i++) begin
        if (wb_sel_i[i]) rd_word[8*i +: 8] = wb_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < dw / 8; i++) begin
        if (wb_sel_i[i]) mem[wr_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    bte_d   = bte_q;
    case (state_q)
      StIdle: begin
        if (req && !ack_q && !err_q) begin
          if (!in_range(wb_adr_i)) begin
            err_d = 1'b1;
            ack_d = 1'b0;
          end else begin
            ack_d = 1'b1;
            dat_d = rd_word;
            if (wb_cti_i == CtiIncr) begin
              state_d = StBurst;
              cnt_d   = next_adr(wb_adr_i, wb_bte_i);
              bte_d   = wb_bte_i;
            end
          end
        end else begin
          ack_d = 1'b0;
        end
      end
      StBurst: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
          ack_d   = 1'b0;
        end else if (!wb_stb_i) begin
          ack_d = ack_q;
        end else if (wb_cti_i != CtiIncr) begin
          // End-of-burst, or the master fell back to classic: this beat is the last.
          state_d = StIdle;
          ack_d   = 1'b0;
        end else if (!in_range(cnt_q)) begin
          state_d = StIdle;
          ack_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          dat_d = rd_word;
          cnt_d = next_adr(cnt_q, bte_q);
        end
      end
      default: begin
        state_d = StIdle;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      bte_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      bte_q   <= bte_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: table of classic vectors, hand-written burst corner
// cases and randomized classic/burst traffic against an associative-array memory model.
module tb_wb_burst_ram;

  localparam logic [31:0] MemSize  = 32'h0002_0000;
  localparam logic [31:0] Sentinel = 32'h0000_0FF0;
  localparam int          NVec     = 16;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [1:0]  bte;
  logic [2:0]  cti;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int unsigned];
  vec_t vecs [NVec];

  always #5 clk = ~clk;

  wb_burst_ram dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_bte_i (bte),
    .wb_cti_i (cti),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_sel_i (sel),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Address of beat k: linear steps by 4, wraps stay inside an aligned 4/8/16-word block.
  function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [1:0] b,
                                            input int k);
    logic [31:0] blk, off;
    if (b == 2'b00) return s + 32'(4 * k);
    blk = 32'd8 << b;
    off = s % blk;
    return (s - off) + ((off + 32'(4 * k)) % blk);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] s,
                                      input logic [31:0] d);
    logic [31:0] m, old;
    m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    old = model.exists(a >> 2) ? model[a >> 2] : 32'hxxxx_xxxx;
    model[a >> 2] = (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model.exists(a >> 2) ? model[a >> 2] : 32'hxxxx_xxxx;
  endfunction

  task automatic classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic got_ack, output logic got_err,
                         output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d; cti = 3'b000; bte = 2'b00;
    lat = 0;
    @(negedge clk);
    while (!(ack || err) && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    got_ack = ack;
    got_err = err;
    rd      = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input string tag);
    logic ga, ge, oor;
    logic [31:0] rd;
    int lat;
    oor = (a >= MemSize);
    classic(w, a, s, d, ga, ge, rd, lat);
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " ack"}, 32'(ga), 32'(!oor));
    chk({tag, " err"}, 32'(ge), 32'(oor));
    if (!oor) begin
      if (w) model_write(a, s, d);
      else chk({tag, " rdata"}, rd, model_rd(a));
    end
  endtask

  // Registered-feedback burst; an optional stb-low wait follows beat wait_after, during
  // which a garbage write to Sentinel is presented and must never land.
  task automatic burst(input logic [31:0] start, input logic [1:0] b, input int n,
                       input logic [15:0] we_mask, input logic rand_sel,
                       input int wait_after, input int wait_len, input string tag);
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        oor, stop;
    int          lat;
    stop = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < n && !stop; k++) begin
      a   = beat_addr(start, b, k);
      d   = $urandom;
      s   = rand_sel ? 4'($urandom) : 4'hF;
      oor = (a >= MemSize);
      cyc = 1'b1; stb = 1'b1; adr = a; we = we_mask[k]; sel = s; dat_i = d; bte = b;
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      lat = 0;
      @(negedge clk);
      while (!(ack || err) && lat < 8) begin
        lat++;
        @(negedge clk);
      end
      chk({tag, " beat latency"}, 32'(lat), (k == 0) ? 32'd1 : 32'd0);
      chk({tag, " beat ack"}, 32'(ack), 32'(!oor));
      chk({tag, " beat err"}, 32'(err), 32'(oor));
      if (oor || !(ack || err)) stop = 1'b1;
      else if (we_mask[k]) model_write(a, s, d);
      else chk({tag, " beat rdata"}, dat_o, model_rd(a));
      @(posedge clk); #1;
      if (k == wait_after && k < n - 1 && !stop) begin
        stb = 1'b0; we = 1'b1; adr = Sentinel; sel = 4'hF; dat_i = 32'hBAD0_BAD0;
        repeat (wait_len) begin
          @(negedge clk);
          chk({tag, " wait quiet"}, 32'(ack || err), 32'd0);
          @(posedge clk); #1;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  initial begin
    logic ga, ge;
    logic [31:0] rd;
    int lat;

    vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0200, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0200, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h5A5A_5A5A, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0002_0000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0002_0000, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'h5A5A_5A5A};
    vecs[9]  = '{1'b1, 32'h0001_FFF8, 4'hF, 32'hC0FF_EE01, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0001_FFFC, 4'hF, 32'hC0FF_EE02, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0001_FFFC, 4'hF, 32'h0,         1'b0, 32'hC0FF_EE02};
    vecs[12] = '{1'b1, Sentinel,      4'hF, 32'h600D_F00D, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0001_FFF8, 4'hF, 32'h0,         1'b0, 32'hC0FF_EE01};
    vecs[14] = '{1'b1, 32'h0000_0100, 4'h0, 32'h1234_5678, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};

    // Reset held with a live request: nothing may terminate.
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF;
    dat_i = '0; cti = 3'b000; bte = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset dat", dat_o, 32'd0);
    chk("rty tied", 32'(rty), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #2 rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      classic(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, ga, ge, rd, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d ack", i), 32'(ga), 32'(!vecs[i].exp_err));
      chk($sformatf("vec%0d err", i), 32'(ge), 32'(vecs[i].exp_err));
      if (!vecs[i].we && !vecs[i].exp_err)
        chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].we && !vecs[i].exp_err) model_write(vecs[i].adr, vecs[i].sel, vecs[i].dat);
    end

    // Classic ack is a single-cycle pulse even with the request still held.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF; cti = 3'b000; bte = 2'b00;
    @(negedge clk); chk("pulse pre", 32'(ack), 32'd0);
    @(negedge clk); chk("pulse ack", 32'(ack), 32'd1);
    chk("pulse rdata", dat_o, 32'hDEAD_BEEF);
    @(negedge clk); chk("pulse drop", 32'(ack), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) do_classic(1'b1, 32'h30 + 32'(4 * i), 4'hF, 32'(12 + i), "preload");
    burst(32'h38, 2'b01, 4, 16'h0000, 1'b0, -1, 0, "wrap4 read");

    do_classic(1'b1, 32'h1020, 4'hF, 32'h7777_7777, "guard write");
    burst(32'h1000, 2'b00, 8, 16'h00FF, 1'b0, 2, 2, "linear write");
    burst(32'h1000, 2'b00, 8, 16'h0000, 1'b0, -1, 0, "linear readback");
    do_classic(1'b0, 32'h1020, 4'hF, 32'h0, "guard read");
    do_classic(1'b0, Sentinel, 4'hF, 32'h0, "sentinel read");

    burst(32'h0001_FFF8, 2'b00, 4, 16'h0000, 1'b0, -1, 0, "edge burst");

    for (int i = 0; i < 4; i++)
      burst(32'h400 + 32'(64 * i), 2'b00, 16, 16'hFFFF, 1'b0, -1, 0, "init burst");

    for (int t = 0; t < 40; t++) begin
      int unsigned kind, n, sw;
      logic [1:0] b;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        do_classic(1'($urandom), 32'h400 + 32'(4 * $urandom_range(0, 63)), 4'($urandom),
                   $urandom, "rand classic");
      end else begin
        b  = 2'($urandom);
        n  = $urandom_range(2, 8);
        sw = (b == 2'b00) ? $urandom_range(0, 64 - n) : $urandom_range(0, 63);
        burst(32'h400 + 32'(4 * sw), b, int'(n), 16'($urandom), 1'b1,
              int'($urandom_range(0, n)), int'($urandom_range(1, 2)), "rand burst");
      end
    end
    do_classic(1'b0, Sentinel, 4'hF, 32'h0, "sentinel final");

    // Asynchronous reset in the third beat of a linear read burst.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h400; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1; adr = 32'h404;
    @(posedge clk); #1; adr = 32'h408;
    #1;
    chk("pre-reset ack", 32'(ack), 32'd1);
    chk("pre-reset rdata", dat_o, model_rd(32'h408));
    #1 rst_n = 1'b0;
    #1;
    chk("async reset ack", 32'(ack), 32'd0);
    chk("async reset err", 32'(err), 32'd0);
    chk("async reset dat", dat_o, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    #2 rst_n = 1'b1;
    do_classic(1'b0, 32'h100, 4'hF, 32'h0, "post-reset read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
